// File: rtl/iv_port_if.sv
// IV-bus control strobes shared by the processor (master) and peripheral ports (slave).
interface iv_port_if;
  logic SC;
  logic WC;
  logic LB;
  logic RB;

  modport master (output SC, output WC, output LB, output RB);
  modport slave  (input  SC, input  WC, input  LB, input  RB);
endinterface

// File: rtl/iv_port.sv
// IV-bus peripheral port: a write-only data register, a status register and a
// 4-entry receive FIFO the processor reads through the active-low, bit-reversed IV bus.
module iv_port #(
  parameter logic [7:0] ADDR = 8'h20,
  parameter bit         BANK = 1'b0
) (
  input  logic         MCLK,
  input  logic         reset,
  iv_port_if.slave     bus,
  inout  wire  [7:0]   IV,
  output logic [7:0]   dout,
  output logic         dout_stb,
  input  logic [7:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         iv_oe,
  output logic [1:0]   dbg_sel
);

  // Handshakes: the processor side uses SC/WC cycles qualified by the bank enable and
  // sampled on the MCLK rising edge; the user side pushes when din_valid && din_ready,
  // except that a push into a full FIFO is still accepted when a pop happens on that edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STAT = 2'd2
  } sel_t;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  sel_t        sel, sel_next;
  logic [7:0]  d;
  logic        bank_act;
  logic        rd_act, wr_data, wr_stat, pop, push, ovf_set, stat_rd;
  logic [7:0]  rd_val;

  logic [7:0]  mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  count;
  logic        overflow, dout_pending;
  logic        full;

  assign bank_act  = BANK ? !bus.RB : !bus.LB;
  assign d         = ~rev8(IV);
  assign full      = count[2];
  assign din_ready = (count < 3'd4);
  assign dbg_sel   = sel;

  // SC has priority, so SC and WC together behave as a select cycle.
  assign wr_data = bank_act && bus.WC && !bus.SC && (sel == S_DATA);
  assign wr_stat = bank_act && bus.WC && !bus.SC && (sel == S_STAT);
  assign pop     = rd_act && (sel == S_DATA) && (count != 3'd0);
  assign stat_rd = rd_act && (sel == S_STAT);
  assign push    = din_valid && (!full || pop);
  assign ovf_set = din_valid && full && !pop;

  // Select register: state register
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) sel <= S_IDLE;
    else        sel <= sel_next;
  end

  // Select register: next state
  always_comb begin
    sel_next = sel;
    if (bank_act && bus.SC) begin
      if (d == ADDR)              sel_next = S_DATA;
      else if (d == ADDR + 8'd1)  sel_next = S_STAT;
      else                        sel_next = S_IDLE;
    end
  end

  // Select register: outputs (read cycle decode and read value)
  always_comb begin
    rd_act = bank_act && !bus.SC && !bus.WC && (sel != S_IDLE);
    iv_oe  = rd_act;
    rd_val = 8'h00;
    case (sel)
      S_DATA:  rd_val = (count != 3'd0) ? mem[rp] : 8'h00;
      S_STAT:  rd_val = {count, 3'b000, overflow, dout_pending};
      default: rd_val = 8'h00;
    endcase
  end

  // Sel resets asynchronously, so the bus is released the moment reset falls.
  assign IV = iv_oe ? ~rev8(rd_val) : 8'hzz;

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      wp           <= 2'd0;
      rp           <= 2'd0;
      count        <= 3'd0;
      overflow     <= 1'b0;
      dout_pending <= 1'b0;
      dout         <= 8'h00;
      dout_stb     <= 1'b0;
    end else begin
      dout_stb <= wr_data;
      if (wr_data) dout <= d;
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (ovf_set)               overflow <= 1'b1;
      else if (wr_stat && d[1])  overflow <= 1'b0;
      if (wr_data)       dout_pending <= 1'b1;
      else if (stat_rd)  dout_pending <= 1'b0;
    end
  end

  // On a full-FIFO push+pop wp equals rp: the head is read combinationally before this overwrite.
  always_ff @(posedge MCLK) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: tb/tb_iv_port.sv
// Directed bench for iv_port (ADDR=8'h20, BANK=0); expected IV pin values are hand-encoded.
module tb_iv_port;

  logic        MCLK;
  logic        reset;
  logic [7:0]  dout;
  logic        dout_stb;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        iv_oe;
  logic [1:0]  dbg_sel;
  logic [7:0]  tb_iv;
  logic        tb_drv;
  wire  [7:0]  iv_w;

  int n_chk  = 0;
  int n_fail = 0;

  iv_port_if bus ();

  assign iv_w = tb_drv ? tb_iv : 8'hzz;

  iv_port #(.ADDR(8'h20), .BANK(1'b0)) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .bus       (bus.slave),
    .IV        (iv_w),
    .dout      (dout),
    .dout_stb  (dout_stb),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .iv_oe     (iv_oe),
    .dbg_sel   (dbg_sel)
  );

  // Clock
  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.SC = 1'b0;
    bus.WC = 1'b0;
    bus.LB = 1'b1;
    bus.RB = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic sel_cyc(input logic [7:0] pins, input logic lb, input logic rb, input logic wc);
    bus.SC = 1'b1;
    bus.WC = wc;
    bus.LB = lb;
    bus.RB = rb;
    tb_iv  = pins;
    tb_drv = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic wr_cyc(input logic [7:0] pins);
    bus.SC = 1'b0;
    bus.WC = 1'b1;
    bus.LB = 1'b0;
    bus.RB = 1'b1;
    tb_iv  = pins;
    tb_drv = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic push(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // One read cycle with LB=0; optionally pushes a byte on the same edge.
  task automatic rd_cyc(input string tag, input logic [7:0] exp_pins,
                        input logic push_en, input logic [7:0] push_b);
    bus.SC = 1'b0;
    bus.WC = 1'b0;
    bus.LB = 1'b0;
    bus.RB = 1'b1;
    tb_drv = 1'b0;
    din       = push_b;
    din_valid = push_en;
    #3;
    check({tag, "_oe"}, {7'd0, iv_oe}, 8'h01);
    check(tag, iv_w, exp_pins);
    tick();
    din_valid = 1'b0;
    bus_idle();
  endtask

  initial begin
    reset     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    tb_iv     = 8'h00;
    bus_idle();

    // Reset state
    #3;
    check("rst_dout", dout, 8'h00);
    check("rst_stb", {7'd0, dout_stb}, 8'h00);
    check("rst_ready", {7'd0, din_ready}, 8'h01);
    check("rst_oe", {7'd0, iv_oe}, 8'h00);
    check("rst_sel", {6'd0, dbg_sel}, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // Data register write: select 0x20 (pins FB), write 0x0C (pins CF)
    sel_cyc(8'hFB, 1'b0, 1'b1, 1'b0);
    check("sel_data", {6'd0, dbg_sel}, 8'h01);
    wr_cyc(8'hCF);
    check("wr_dout", dout, 8'h0C);
    check("wr_stb_hi", {7'd0, dout_stb}, 8'h01);
    tick();
    check("wr_stb_lo", {7'd0, dout_stb}, 8'h00);

    // SC and WC together act as select only
    sel_cyc(8'hFB, 1'b0, 1'b1, 1'b1);
    check("scwc_dout", dout, 8'h0C);
    check("scwc_stb", {7'd0, dout_stb}, 8'h00);
    check("scwc_sel", {6'd0, dbg_sel}, 8'h01);

    // Status: pending set (0x01 -> 7F), then cleared by the read (0x00 -> FF)
    sel_cyc(8'h7B, 1'b0, 1'b1, 1'b0);
    check("sel_stat", {6'd0, dbg_sel}, 8'h02);
    rd_cyc("stat_pend", 8'h7F, 1'b0, 8'h00);
    rd_cyc("stat_clr", 8'hFF, 1'b0, 8'h00);

    // FIFO reads: A5 (5A), 3C (C3), then empty 00 (FF)
    push(8'hA5);
    push(8'h3C);
    sel_cyc(8'hFB, 1'b0, 1'b1, 1'b0);
    rd_cyc("rd_a5", 8'h5A, 1'b0, 8'h00);
    rd_cyc("rd_3c", 8'hC3, 1'b0, 8'h00);
    rd_cyc("rd_empty", 8'hFF, 1'b0, 8'h00);
    sel_cyc(8'h7B, 1'b0, 1'b1, 1'b0);
    rd_cyc("stat_cnt0", 8'hFF, 1'b0, 8'h00);

    // Fill and overflow
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("ready_cnt3", {7'd0, din_ready}, 8'h01);
    push(8'h44);
    check("ready_full", {7'd0, din_ready}, 8'h00);
    push(8'h55);
    check("ready_ovf", {7'd0, din_ready}, 8'h00);
    rd_cyc("stat_82", 8'hBE, 1'b0, 8'h00);
    wr_cyc(8'hBF);
    rd_cyc("stat_80", 8'hFE, 1'b0, 8'h00);

    // Full FIFO: push 0x66 during a data read
    sel_cyc(8'hFB, 1'b0, 1'b1, 1'b0);
    rd_cyc("rd_11_push", 8'h77, 1'b1, 8'h66);
    check("ready_pp", {7'd0, din_ready}, 8'h00);
    rd_cyc("rd_22", 8'hBB, 1'b0, 8'h00);
    rd_cyc("rd_33", 8'h33, 1'b0, 8'h00);
    rd_cyc("rd_44", 8'hDD, 1'b0, 8'h00);
    rd_cyc("rd_66", 8'h99, 1'b0, 8'h00);
    rd_cyc("rd_empty2", 8'hFF, 1'b0, 8'h00);
    sel_cyc(8'h7B, 1'b0, 1'b1, 1'b0);
    rd_cyc("stat_after_pp", 8'hFF, 1'b0, 8'h00);

    // Bank qualification
    sel_cyc(8'hFB, 1'b1, 1'b0, 1'b0);
    check("rb_sel_kept", {6'd0, dbg_sel}, 8'h02);
    bus.LB = 1'b1;
    bus.RB = 1'b0;
    #3;
    check("rb_no_drive", {7'd0, iv_oe}, 8'h00);
    tick();
    bus_idle();
    sel_cyc(8'hDD, 1'b0, 1'b1, 1'b0);
    check("sel_idle", {6'd0, dbg_sel}, 8'h00);
    wr_cyc(8'h55);
    check("idle_wr_dout", dout, 8'h0C);
    check("idle_wr_stb", {7'd0, dout_stb}, 8'h00);
    bus.LB = 1'b0;
    #3;
    check("idle_no_drive", {7'd0, iv_oe}, 8'h00);
    tick();
    bus_idle();

    // Reset in the middle of a data read with two entries (head 0x77 -> pins 11)
    push(8'h77);
    push(8'h88);
    sel_cyc(8'hFB, 1'b0, 1'b1, 1'b0);
    bus.LB = 1'b0;
    #2;
    check("prerst_oe", {7'd0, iv_oe}, 8'h01);
    check("prerst_val", iv_w, 8'h11);
    reset = 1'b0;
    #1;
    check("midrst_oe", {7'd0, iv_oe}, 8'h00);
    check("midrst_ready", {7'd0, din_ready}, 8'h01);
    bus_idle();
    tick();
    reset = 1'b1;
    tick();
    check("postrst_sel", {6'd0, dbg_sel}, 8'h00);
    sel_cyc(8'h7B, 1'b0, 1'b1, 1'b0);
    rd_cyc("postrst_stat", 8'hFF, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iv_port.md
IV_PORT -- requirements
Module: iv_port

Interface
REQ-001 Parameter ADDR, default 8'h20, even IV-bus address of the data register; ADDR+1 is the status register.
REQ-002 Parameter BANK, default 0, 0 responds on LB, 1 responds on RB.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Port MCLK is the clock; port reset is the active-low asynchronous reset.
REQ-004 MCLK  input  1  processor machine clock; all state changes on its rising edge.
REQ-005 reset  input  1  active-low asynchronous reset.
REQ-006 IV  inout  8  interface-vector bus; active-low, bit-reversed (pin IV[i] = ~logical[7-i]).
REQ-007 SC  input  1  select-command (address) cycle, active-high.
REQ-008 WC  input  1  write-command (data) cycle, active-high.
REQ-009 LB  input  1  left-bank enable, active-low.
REQ-010 RB  input  1  right-bank enable, active-low.
REQ-011 dout  output  8  last byte written to the data register.
REQ-012 dout_stb  output  1  one-cycle pulse when dout updates.
REQ-013 din  input  8  user byte to be read by the processor.
REQ-014 din_valid  input  1  user push request.
REQ-015 din_ready  output  1  FIFO not full.

Function
REQ-016 bank_act = !LB when BANK=0, !RB when BANK=1; logical bus value d = ~bitreverse(IV).
REQ-017 Select register sel[1:0] states: IDLE, DATA, STAT.
REQ-018 At an MCLK edge with SC && bank_act: d==ADDR -> DATA; d==ADDR+1 -> STAT; any other d -> IDLE.
REQ-019 SC or WC with the bank inactive leaves sel unchanged.
REQ-020 At an MCLK edge with WC && bank_act && sel==DATA: dout <= d and dout_stb = 1 for the following cycle.
REQ-021 At an MCLK edge with WC && bank_act && sel==STAT: a write with d[1]=1 clears the overflow flag.
REQ-022 Read cycle = bank_act && !SC && !WC && sel!=IDLE. IV is driven combinationally with the encoded read value only during a read cycle; otherwise IV is high-Z.
REQ-023 Read value in DATA: FIFO head, or 8'h00 when the FIFO is empty.
REQ-024 Read value in STAT: {count[2:0], 3'b000, overflow, dout_pending}.
REQ-025 dout_pending is set by a data write and cleared by a status read.
REQ-026 Receive FIFO: 4 entries, 3-bit count (0..4); din_ready = (count < 4).
REQ-027 Push occurs on an edge with din_valid && din_ready.
REQ-028 din_valid while full sets overflow sticky; din is dropped and the FIFO is unchanged.
REQ-029 Pop occurs at the MCLK edge ending a DATA read cycle when count > 0; a read of an empty FIFO pops nothing.
REQ-030 Simultaneous push and pop: count is unchanged, the head advances, and the new byte is appended; this applies also when count==4.
REQ-031 Pointers wrap modulo 4.
REQ-032 A status read pops nothing.
REQ-033 SC and WC both high is illegal; the block shall treat it as SC only.
REQ-034 IV drive never depends on registered read state: the value reflects the current head, so a push during a read of an empty FIFO may change IV mid-cycle.

Reset
REQ-035 While reset is low: sel=IDLE, dout=8'h00, dout_stb=0, FIFO empty (count=0, pointers 0), overflow=0, dout_pending=0, din_ready=1, IV high-Z.
REQ-036 Reset asserted mid-cycle aborts any read or write immediately; IV releases asynchronously.

Verification
REQ-037 ADDR=8'h20, BANK=0; SC, LB=0, IV=~rev(8'h20)=8'hFB; then WC, LB=0, logical 8'h0C (IV=8'hCF) -> dout=8'h0C, dout_stb high exactly one cycle.
REQ-038 Push 8'hA5 then 8'h3C; select DATA; two read cycles with LB=0 -> logical reads 8'hA5 then 8'h3C; count returns to 0; a third read returns 8'h00.
REQ-039 Push 5 bytes with no reads -> din_ready=0 after the 4th; status read returns 8'h82 (count 4, overflow set); status write of 8'h02 -> overflow clears.
REQ-040 Select address 8'h20 with RB=0, LB=1 (BANK=0) -> sel unchanged, IV stays high-Z; then SC on LB with 8'h44 -> sel=IDLE, subsequent WC ignored.
REQ-041 With count=4, push and DATA read in the same cycle -> count stays 4, the next read returns the old second entry, and the new byte lands last.
REQ-042 Assert reset during a DATA read with count=2 -> IV high-Z immediately, count=0, sel=IDLE after release.
